// File: rtl/mvu_pkg.sv
// Shared widths, multiplier-mode encodings and the job descriptor for the MVU controllers.
package mvu_pkg;
  localparam int BWBANKA = 9;
  localparam int BDBANKA = 14;
  localparam int BTILE   = 8;
  localparam int BPREC   = 4;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_1    = 2'b01;
  localparam logic [1:0] MODE_2    = 2'b10;
  localparam logic [1:0] MODE_3    = 2'b11;

  typedef struct packed {
    logic [BWBANKA-1:0] wbase;
    logic [BDBANKA-1:0] dbase;
    logic [BDBANKA-1:0] obase;
    logic [BTILE-1:0]   ntile;
    logic [BPREC-1:0]   nprec;
    logic [1:0]         mode;
  } job_t;
endpackage

// File: rtl/mvu_ctrl_agu.sv
// Tile/plane counters and read-address generation; the data plane base is accumulated
// by ntile+1 per plane so no multiplier is needed. Advances only on a granted read.
module mvu_ctrl_agu
  import mvu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [BDBANKA-1:0] i_ld_dbase,
  input  logic               i_adv,
  input  logic [BWBANKA-1:0] i_wbase,
  input  logic [BTILE-1:0]   i_ntile,
  input  logic [BPREC-1:0]   i_nprec,
  output logic [BWBANKA-1:0] o_rdw_addr,
  output logic [BDBANKA-1:0] o_rdd_addr,
  output logic               o_last_t,
  output logic               o_last_p,
  output logic               o_t_zero,
  output logic               o_p_zero
);
  logic [BTILE-1:0]   r_t;
  logic [BPREC-1:0]   r_p;
  logic [BDBANKA-1:0] r_pbase;
  logic [BDBANKA-1:0] w_stride;

  assign w_stride = BDBANKA'(i_ntile) + BDBANKA'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t     <= '0;
      r_p     <= '0;
      r_pbase <= '0;
    end else if (i_load) begin
      r_t     <= '0;
      r_p     <= '0;
      r_pbase <= i_ld_dbase;
    end else if (i_adv) begin
      if (o_last_t) begin
        r_t     <= '0;
        r_p     <= r_p + BPREC'(1);
        r_pbase <= r_pbase + w_stride;
      end else begin
        r_t <= r_t + BTILE'(1);
      end
    end
  end

  assign o_rdw_addr = i_wbase + BWBANKA'(r_t);
  assign o_rdd_addr = r_pbase + BDBANKA'(r_t);
  assign o_last_t   = (r_t == i_ntile);
  assign o_last_p   = (r_p == i_nprec);
  assign o_t_zero   = (r_t == '0);
  assign o_p_zero   = (r_p == '0);
endmodule

// File: rtl/mvu_ctrl.sv
// Per-MVU job sequencer: accept a descriptor, issue bit-serial reads, drain, write back.
// Accumulator controls are gated by rdd_grnt so a stalled read contributes nothing.
module mvu_ctrl
  import mvu_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [BWBANKA-1:0] job_wbase,
  input  logic [BDBANKA-1:0] job_dbase,
  input  logic [BDBANKA-1:0] job_obase,
  input  logic [BTILE-1:0]   job_ntile,
  input  logic [BPREC-1:0]   job_nprec,
  input  logic [1:0]         job_mode,
  output logic [1:0]         mul_mode,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic               busy,
  output logic               done
);
  localparam int BDCNT = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_t;

  state_t           r_state, w_state_nxt;
  job_t             r_job;
  logic             r_first;
  logic [BDCNT-1:0] r_dcnt;
  logic             w_hs, w_adv;
  logic             w_last_t, w_last_p, w_t_zero, w_p_zero;

  assign w_hs      = job_valid & rst_n & (r_state == S_IDLE);
  assign w_adv     = (r_state == S_ISSUE) & rdd_grnt;
  assign job_ready = rst_n & (r_state == S_IDLE);
  assign wrd_addr  = r_job.obase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_job   <= '0;
      r_first <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_job   <= '{wbase: job_wbase, dbase: job_dbase, obase: job_obase,
                     ntile: job_ntile, nprec: job_nprec, mode: job_mode};
        r_first <= 1'b1;
      end else if (w_adv) begin
        r_first <= 1'b0;
      end
      r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + BDCNT'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rdd_en      = 1'b0;
    wrd_en      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mul_mode    = MODE_IDLE;
    acc_clr     = 1'b0;
    acc_sh      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        busy     = 1'b1;
        rdd_en   = 1'b1;
        mul_mode = r_job.mode & {2{rdd_grnt}};
        acc_clr  = r_first & rdd_grnt;
        // Shift once at the head of each plane after the MSB plane.
        acc_sh   = rdd_grnt & w_t_zero & ~w_p_zero;
        if (rdd_grnt && w_last_t && w_last_p) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_dcnt == BDCNT'(LAT - 1)) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        wrd_en = 1'b1;
        if (wrd_grnt) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  mvu_ctrl_agu u_agu (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_hs),
    .i_ld_dbase (job_dbase),
    .i_adv      (w_adv),
    .i_wbase    (r_job.wbase),
    .i_ntile    (r_job.ntile),
    .i_nprec    (r_job.nprec),
    .o_rdw_addr (rdw_addr),
    .o_rdd_addr (rdd_addr),
    .o_last_t   (w_last_t),
    .o_last_p   (w_last_p),
    .o_t_zero   (w_t_zero),
    .o_p_zero   (w_p_zero)
  );
endmodule

// File: tb/tb_mvu_ctrl.sv
// Scoreboard bench for mvu_ctrl: directed jobs push expected reads/writes, a negedge monitor checks them.
module tb_mvu_ctrl;
  import mvu_pkg::*;

  localparam int LAT = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [BWBANKA-1:0] job_wbase = '0;
  logic [BDBANKA-1:0] job_dbase = '0;
  logic [BDBANKA-1:0] job_obase = '0;
  logic [BTILE-1:0]   job_ntile = '0;
  logic [BPREC-1:0]   job_nprec = '0;
  logic [1:0]         job_mode = '0;
  logic [1:0]         mul_mode;
  logic               acc_clr, acc_sh, rdd_en, wrd_en, busy, done;
  logic               rdd_grnt = 1'b1;
  logic               wrd_grnt = 1'b1;
  logic [BWBANKA-1:0] rdw_addr;
  logic [BDBANKA-1:0] rdd_addr, wrd_addr;

  mvu_ctrl #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_wbase(job_wbase), .job_dbase(job_dbase), .job_obase(job_obase),
    .job_ntile(job_ntile), .job_nprec(job_nprec), .job_mode(job_mode),
    .mul_mode(mul_mode), .acc_clr(acc_clr), .acc_sh(acc_sh), .rdw_addr(rdw_addr),
    .rdd_en(rdd_en), .rdd_grnt(rdd_grnt), .rdd_addr(rdd_addr),
    .wrd_en(wrd_en), .wrd_grnt(wrd_grnt), .wrd_addr(wrd_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BWBANKA-1:0] w;
    logic [BDBANKA-1:0] d;
    logic [1:0]         m;
    logic               c;
    logic               s;
  } rd_t;

  rd_t                rd_q[$];
  logic [BDBANKA-1:0] wr_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int last_rd_cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_rd(input logic [BWBANKA-1:0] w, input logic [BDBANKA-1:0] d,
                         input logic [1:0] m, input logic c, input logic s);
    rd_q.push_back('{w: w, d: d, m: m, c: c, s: s});
  endtask

  task automatic send_job(input logic [BWBANKA-1:0] w, input logic [BDBANKA-1:0] d,
                          input logic [BDBANKA-1:0] o, input logic [BTILE-1:0] nt,
                          input logic [BPREC-1:0] np, input logic [1:0] m, input bit hold);
    int n = 0;
    @(posedge clk); #1;
    job_wbase = w; job_dbase = d; job_obase = o;
    job_ntile = nt; job_nprec = np; job_mode = m;
    job_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!job_ready && n < 200);
    check("job_accept", 32'(job_ready), 32'd1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) job_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("job_complete", 32'(rd_q.size() + wr_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_vals(input logic exp_ready);
    check("rst_job_ready", 32'(job_ready), 32'(exp_ready));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdd_en", 32'(rdd_en), 32'd0);
    check("rst_wrd_en", 32'(wrd_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ctl", 32'({mul_mode, acc_clr, acc_sh}), 32'd0);
    check("rst_addr", 32'({rdw_addr, rdd_addr, wrd_addr}), 32'd0);
  endtask

  // Monitor: compares every granted read and every write cycle against the queues.
  logic               prev_stall = 1'b0, prev_wrd_en = 1'b0, prev_done = 1'b0;
  logic [BWBANKA-1:0] prev_rdw = '0;
  logic [BDBANKA-1:0] prev_rdd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdd_en && rdd_grnt) begin
        check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          rd_t e;
          e = rd_q.pop_front();
          check("rdw_addr", 32'(rdw_addr), 32'(e.w));
          check("rdd_addr", 32'(rdd_addr), 32'(e.d));
          check("mul_mode", 32'(mul_mode), 32'(e.m));
          check("acc_clr", 32'(acc_clr), 32'(e.c));
          check("acc_sh", 32'(acc_sh), 32'(e.s));
        end
        if (acc_clr) check("first_rd_lat", 32'(cyc), 32'(hs_cyc + 1));
        last_rd_cyc = cyc;
      end
      if (rdd_en && !rdd_grnt)
        check("stall_ctl_zero", 32'({mul_mode, acc_clr, acc_sh}), 32'd0);
      if (prev_stall) begin
        check("stall_rdd_en", 32'(rdd_en), 32'd1);
        check("stall_rdw_hold", 32'(rdw_addr), 32'(prev_rdw));
        check("stall_rdd_hold", 32'(rdd_addr), 32'(prev_rdd));
      end
      if (wrd_en) begin
        if (!prev_wrd_en) check("wr_lat", 32'(cyc - last_rd_cyc), 32'(LAT + 1));
        check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) check("wrd_addr", 32'(wrd_addr), 32'(wr_q[0]));
        check("done_vs_grnt", 32'(done), 32'(wrd_grnt));
        if (wrd_grnt && wr_q.size() != 0) void'(wr_q.pop_front());
      end else if (done) begin
        check("done_spurious", 32'(done), 32'd0);
      end
      if (done) done_cyc = cyc;
      if (prev_done) check("ready_after_done", 32'(job_ready), 32'd1);
      if (rdd_en || wrd_en) check("busy_active", 32'(busy), 32'd1);
      if (job_ready) check("busy_idle", 32'(busy), 32'd0);
      prev_stall  = rdd_en && !rdd_grnt;
      prev_rdw    = rdw_addr;
      prev_rdd    = rdd_addr;
      prev_wrd_en = wrd_en;
      prev_done   = done;
    end else begin
      prev_stall  = 1'b0;
      prev_wrd_en = 1'b0;
      prev_done   = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals(1'b1);

    // Basic job, grants tied high.
    push_rd(9'h010, 14'h0100, 2'd1, 1'b1, 1'b0);
    push_rd(9'h011, 14'h0101, 2'd1, 1'b0, 1'b0);
    push_rd(9'h012, 14'h0102, 2'd1, 1'b0, 1'b0);
    push_rd(9'h010, 14'h0103, 2'd1, 1'b0, 1'b1);
    push_rd(9'h011, 14'h0104, 2'd1, 1'b0, 1'b0);
    push_rd(9'h012, 14'h0105, 2'd1, 1'b0, 1'b0);
    wr_q.push_back(14'h0200);
    send_job(9'h010, 14'h0100, 14'h0200, 8'd2, 4'd1, 2'd1, 1'b0);
    wait_empty();

    // Same job, read grant withheld in ISSUE cycles 2-4.
    push_rd(9'h010, 14'h0100, 2'd1, 1'b1, 1'b0);
    push_rd(9'h011, 14'h0101, 2'd1, 1'b0, 1'b0);
    push_rd(9'h012, 14'h0102, 2'd1, 1'b0, 1'b0);
    push_rd(9'h010, 14'h0103, 2'd1, 1'b0, 1'b1);
    push_rd(9'h011, 14'h0104, 2'd1, 1'b0, 1'b0);
    push_rd(9'h012, 14'h0105, 2'd1, 1'b0, 1'b0);
    wr_q.push_back(14'h0200);
    send_job(9'h010, 14'h0100, 14'h0200, 8'd2, 4'd1, 2'd1, 1'b0);
    @(posedge clk); #1 rdd_grnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdd_grnt = 1'b1;
    wait_empty();

    // Write grant withheld for 5 cycles; weight address wraps at 9 bits.
    push_rd(9'h1FF, 14'h0040, 2'd2, 1'b1, 1'b0);
    push_rd(9'h000, 14'h0041, 2'd2, 1'b0, 1'b0);
    wr_q.push_back(14'h0ABC);
    wrd_grnt = 1'b0;
    send_job(9'h1FF, 14'h0040, 14'h0ABC, 8'd1, 4'd0, 2'd2, 1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!wrd_en && n < 100);
      check("wr_reached", 32'(wrd_en), 32'd1);
    end
    repeat (5) @(posedge clk);
    #1 wrd_grnt = 1'b1;
    wait_empty();

    // Data address wrap at 14 bits.
    push_rd(9'h005, 14'h3FFE, 2'd3, 1'b1, 1'b0);
    push_rd(9'h006, 14'h3FFF, 2'd3, 1'b0, 1'b0);
    push_rd(9'h007, 14'h0000, 2'd3, 1'b0, 1'b0);
    push_rd(9'h008, 14'h0001, 2'd3, 1'b0, 1'b0);
    wr_q.push_back(14'h0010);
    send_job(9'h005, 14'h3FFE, 14'h0010, 8'd3, 4'd0, 2'd3, 1'b0);
    wait_empty();

    // Reset after three reads: no write may follow.
    push_rd(9'h010, 14'h0100, 2'd1, 1'b1, 1'b0);
    push_rd(9'h011, 14'h0101, 2'd1, 1'b0, 1'b0);
    push_rd(9'h012, 14'h0102, 2'd1, 1'b0, 1'b0);
    send_job(9'h010, 14'h0100, 14'h0200, 8'd2, 4'd1, 2'd1, 1'b0);
    begin
      int n = 0;
      while (rd_q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
    end
    #1 rst_n = 1'b0; rdd_grnt = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; rdd_grnt = 1'b1;
    @(negedge clk);
    check_reset_vals(1'b1);
    push_rd(9'h033, 14'h0777, 2'd1, 1'b1, 1'b0);
    wr_q.push_back(14'h0123);
    send_job(9'h033, 14'h0777, 14'h0123, 8'd0, 4'd0, 2'd1, 1'b0);
    wait_empty();

    // Back-to-back degenerate jobs with job_valid held.
    push_rd(9'h001, 14'h0002, 2'd2, 1'b1, 1'b0);
    wr_q.push_back(14'h0003);
    push_rd(9'h004, 14'h0005, 2'd3, 1'b1, 1'b0);
    wr_q.push_back(14'h0006);
    send_job(9'h001, 14'h0002, 14'h0003, 8'd0, 4'd0, 2'd2, 1'b1);
    send_job(9'h004, 14'h0005, 14'h0006, 8'd0, 4'd0, 2'd3, 1'b0);
    check("b2b_accept_cycle", 32'(hs_cyc), 32'(done_cyc + 1));
    wait_empty();

    repeat (10) @(posedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mvu_ctrl.md
Name: mvu_ctrl

Overview:
- Per-MVU job sequencer; sits directly upstream of the MVU array and drives one MVU's control lanes: mul_mode, acc_clr, acc_sh, rdw_addr, rdd_en/rdd_addr, wrd_en/wrd_addr.
- Accepts a matrix-vector job descriptor over a valid/ready handshake and runs the job to completion.
- Job flow: issue bit-serial weight/data reads over all precision planes and tiles, wait out the MVU pipeline, then write the result word back.
- One instance per MVU; NMVU instances sit beside the array.

Parameters:
BWBANKA, 9, weight bank address width
BDBANKA, 14, data bank address width
BTILE, 8, tile-count field width (up to 256 tiles per job)
BPREC, 4, precision field width (up to 16 activation bit-planes)
LAT, 3, cycles from a granted read to the accumulator update it causes (LAT>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
job_valid  in  1  descriptor valid
job_ready  out  1  descriptor accepted when job_valid&job_ready
job_wbase  in  BWBANKA  first weight address
job_dbase  in  BDBANKA  first data address
job_obase  in  BDBANKA  result write address
job_ntile  in  BTILE  tiles minus one
job_nprec  in  BPREC  bit-planes minus one
job_mode  in  2  multiplier mode for the job
mul_mode  out  2  to MVU; 2'b00 = multiplier idle (contributes zero)
acc_clr  out  1  to MVU accumulator clear
acc_sh  out  1  to MVU accumulator shift-before-add
rdw_addr  out  BWBANKA  weight read address
rdd_en  out  1  data read request
rdd_grnt  in  1  data read grant, same-cycle
rdd_addr  out  BDBANKA  data read address
wrd_en  out  1  data write request
wrd_grnt  in  1  data write grant, same-cycle
wrd_addr  out  BDBANKA  data write address
busy  out  1  job in progress
done  out  1  one-cycle pulse on granted result write

Behaviour:
- Reset (rst_n=0 at a clk edge) forces state IDLE and all counters to 0. Output values while in reset and until the first job: job_ready=0 during reset then 1 in IDLE; mul_mode=0, acc_clr=0, acc_sh=0, rdd_en=0, wrd_en=0, busy=0, done=0; addresses 0.
- Reset mid-job aborts it with no write issued.
- States:
  - IDLE: job_ready=1. Handshake latches the descriptor, clears tile counter t and plane counter p, sets first=1, and goes to ISSUE next cycle.
  - ISSUE:
    - rdd_en=1, rdw_addr=wbase+t, rdd_addr=dbase+p*(ntile+1)+t.
    - Plane order: p=0 is the MSB plane.
    - Address arithmetic is modulo 2^BWBANKA / 2^BDBANKA (wraps silently).
    - Advance only when rdd_grnt=1. t increments; when t==ntile, t wraps to 0 and p increments. After t==ntile and p==nprec are granted, go to DRAIN.
  - DRAIN: counts LAT cycles, then goes to WRITE.
  - WRITE:
    - wrd_en=1, wrd_addr=obase; hold until wrd_grnt=1.
    - On grant: done=1 that cycle; next state IDLE.
- Qualified outputs in ISSUE; these are combinational on rdd_grnt so that a stalled cycle adds nothing:
  - mul_mode = job_mode & {2{rdd_grnt}}.
  - acc_clr = first & rdd_grnt; first clears on the first granted read.
  - acc_sh = rdd_grnt & (t==0) & (p!=0): shift the accumulator at the start of every plane after the first.
  - Outside ISSUE, mul_mode/acc_clr/acc_sh = 0.
- Stalls: on a denied grant, rdd_en, rdw_addr and rdd_addr stay stable.
- busy=1 in ISSUE, DRAIN and WRITE.
- job_ready=0 outside IDLE; a back-to-back job is accepted on the IDLE cycle after done.
- Latency, no stalls: handshake cycle h; reads at h+1 .. h+(ntile+1)(nprec+1); WRITE starts LAT+1 cycles after the last read.
- Degenerate job (ntile=0, nprec=0): exactly one read, with acc_clr=1 and acc_sh=0.

Decomposition:
- Shared package mvu_pkg: BWBANKA, BDBANKA, the mul_mode encodings (including MODE_IDLE=2'b00), and the job descriptor struct type with fields wbase, dbase, obase, ntile, nprec, mode.
- One sub-module, mvu_ctrl_agu: holds the t/p counters and plane-base accumulation; produces rdw_addr/rdd_addr and last-tile/last-plane flags.
- FSM and output qualification stay in mvu_ctrl.

Test Plan:
- Basic job: wbase=0x010, dbase=0x0100, obase=0x0200, ntile=2, nprec=1, mode=1, grants tied 1 -> rdd_addr 0x100,0x101,0x102,0x103,0x104,0x105 with rdw_addr 0x10,0x11,0x12 repeated; acc_clr on read 1 only; acc_sh on read 4 only; wrd_en at 0x200 LAT+1 cycles after read 6; done pulses once.
- Read stall: same job, rdd_grnt=0 for cycles 2-4 of ISSUE -> addresses held; mul_mode=0 and acc_sh=0 during the stall; the same 6 granted reads occur, in order.
- Write stall: wrd_grnt=0 for 5 cycles -> wrd_en/wrd_addr held; done only on the grant cycle; job_ready returns to 1 the next cycle.
- Wrap: dbase=0x3FFE, ntile=3, nprec=0 -> rdd_addr 0x3FFE,0x3FFF,0x0000,0x0001.
- Reset mid-ISSUE: rst_n=0 for 1 cycle after 3 reads -> next cycle IDLE, all outputs at reset values, no wrd_en; a new job then runs cleanly.
- Degenerate/back-to-back: two ntile=0,nprec=0 jobs with job_valid held -> one read each, acc_clr on each, second accepted the cycle after the first done.
